lcd_receiver: RTL and testbench
===============================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 SHALL have no parameters; DDRAM depth fixed at 32 bytes (2 rows x 16), clear duration fixed at 32 cycles.
REQ-002 clk  input  1  rising-edge clock, same clock as the LCD host driver.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 en  input  1  host enable strobe; a nibble is transferred on its falling edge.
REQ-005 rs  input  1  register select: 0 = instruction, 1 = data.
REQ-006 data  input  4  host nibble bus (DB7..DB4).
REQ-007 rd_addr  input  5  DDRAM read index (bit4 = row, bits3:0 = column).
REQ-008 rd_data  output  8  DDRAM contents at rd_addr; combinational read.
REQ-009 cmd_valid  output  1  one-cycle pulse per executed byte.
REQ-010 cmd_byte  output  8  byte executed, valid with cmd_valid.
REQ-011 cmd_rs  output  1  rs of executed byte, valid with cmd_valid.
REQ-012 four_bit  output  1  interface in 4-bit mode.
REQ-013 display_on  output  1  D bit of the last display-control command.
REQ-014 cursor  output  5  current DDRAM write index.
REQ-015 busy  output  1  clear in progress.
REQ-016 err  output  1  sticky protocol-error flag, cleared only by reset.

Function
REQ-017 Nibble capture SHALL occur in the cycle where registered en_q=1 and en=0, sampling data and rs in that cycle.
REQ-018 In 8-bit mode each captured nibble SHALL form byte {data,4'h0} and complete immediately.
REQ-019 In 8-bit mode, a completed instruction byte with upper nibble 2 SHALL set four_bit=1 and clear the nibble phase to high; upper nibble 3 SHALL leave the mode unchanged; any other upper nibble, or rs=1, SHALL set err and execute nothing.
REQ-020 In 4-bit mode the first nibble SHALL be the high nibble and the second the low nibble; the byte completes on the second nibble.
REQ-021 If rs differs between the high and low nibble, the byte SHALL be discarded and err set.
REQ-022 Completed byte effects and cmd_valid/cmd_byte/cmd_rs SHALL be registered on the clock edge following the capture cycle (latency 1).
REQ-023 Instruction decode, highest set bit wins: 0x80 set DDRAM (cursor = {b6,b3:0}; b5 or b4 set additionally sets err); 0x20 function set (b4=1 sets four_bit=0); 0x08 display control (display_on=b2); 0x04 entry mode (inc_mode=b1); 0x02 return home (cursor=0); 0x01 clear.
REQ-024 Clear SHALL set busy=1 and cursor=0, force inc_mode=1, and write 0x20 to index 0..31 over 32 consecutive cycles, one per cycle; busy SHALL deassert in the cycle after index 31 is written.
REQ-025 A data byte (rs=1) SHALL write DDRAM[cursor], then cursor+1 (inc_mode=1) or cursor-1 (inc_mode=0), modulo 32 (31->0, 0->31).
REQ-026 A nibble captured while busy=1 SHALL be dropped and set err; the nibble phase SHALL NOT advance.
REQ-027 A nibble capture coinciding with the final clear cycle SHALL be treated as during busy.

Reset
REQ-028 Reset SHALL set four_bit=0, nibble phase high, display_on=0, inc_mode=1, cursor=0, busy=0, err=0, cmd_valid=0, cmd_byte=0, cmd_rs=0, en_q=0.
REQ-029 DDRAM contents SHALL NOT be cleared by reset; reset mid-byte or mid-clear SHALL abandon the operation.

Structure
REQ-030 Package lcd_pkg SHALL hold instruction bit masks, SPACE=0x20, DDRAM_DEPTH=32, ROW1_BIT=6.
REQ-031 A sub-module lcd_ddram SHALL implement the 32x8 array: one synchronous write port, one asynchronous read port.

Verification
REQ-032 Nibbles 3,3,3,2 then 0x28,0x0C,0x06,0x01 -> four_bit=1, display_on=1, busy high 32 cycles, all 32 bytes read 0x20, cursor=0.
REQ-033 After init, 0xC4 then data 0x31,0x32 -> rd_data[20]=0x31, rd_data[21]=0x32, cursor=22, err=0.
REQ-034 Set DDRAM 0x4F, write 0x41 -> DDRAM[31]=0x41, cursor=0; entry mode 0x04, write 0x42 at cursor 0 -> DDRAM[0]=0x42, cursor=31.
REQ-035 Nibble sent during clear -> err=1, dropped, next full byte decoded correctly.
REQ-036 Reset after high nibble only -> four_bit=0, the next nibble 3 is taken as 8-bit byte 0x30, cmd_valid pulses once with cmd_byte=0x30.
REQ-037 High nibble rs=0, low nibble rs=1 -> err=1, no cmd_valid, DDRAM unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and instruction decode for the HD44780-style LCD receiver.
package lcd_pkg;

  localparam int DDRAM_DEPTH = 32;
  localparam int ADDR_W      = $clog2(DDRAM_DEPTH);
  localparam int ROW1_BIT    = 6;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [7:0] MASK_SET_DDRAM = 8'h80;
  localparam logic [7:0] MASK_FUNC_SET  = 8'h20;
  localparam logic [7:0] MASK_DISPLAY   = 8'h08;
  localparam logic [7:0] MASK_ENTRY     = 8'h04;
  localparam logic [7:0] MASK_HOME      = 8'h02;
  localparam logic [7:0] MASK_CLEAR     = 8'h01;

  // Option bits inside the commands above
  localparam int FUNC_DL_BIT   = 4;
  localparam int DISPLAY_D_BIT = 2;
  localparam int ENTRY_ID_BIT  = 1;
  localparam logic [7:0] SET_DDRAM_BAD = 8'h30;

  typedef enum logic {PH_HIGH, PH_LOW} phase_e;

  typedef enum logic [2:0] {
    OP_NONE, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPLAY, OP_FUNC_SET, OP_SET_DDRAM
  } op_e;

  // Highest set bit selects the command; 0x40 and 0x10 commands are not supported.
  function automatic op_e decode_op(input logic [7:0] b);
    op_e op;
    op = OP_NONE;
    if ((b & MASK_SET_DDRAM) != 8'h00)    op = OP_SET_DDRAM;
    else if (b[6])                        op = OP_NONE;
    else if ((b & MASK_FUNC_SET) != 8'h00) op = OP_FUNC_SET;
    else if (b[4])                        op = OP_NONE;
    else if ((b & MASK_DISPLAY) != 8'h00) op = OP_DISPLAY;
    else if ((b & MASK_ENTRY) != 8'h00)   op = OP_ENTRY;
    else if ((b & MASK_HOME) != 8'h00)    op = OP_HOME;
    else if ((b & MASK_CLEAR) != 8'h00)   op = OP_CLEAR;
    return op;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM: synchronous write, asynchronous read.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_receiver.sv
// Device side of an HD44780-style LCD link: captures host nibbles on en falling
// edges, assembles bytes, executes instructions and writes display data.
module lcd_receiver
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rs,
  input  logic [3:0]        data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              cmd_rs,
  output logic              four_bit,
  output logic              display_on,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output logic              err
);

  logic              en_q;
  phase_e            phase;
  logic [3:0]        hi_nib;
  logic              hi_rs;
  logic              inc_mode;
  logic [ADDR_W-1:0] clr_idx;

  logic              capture, take, byte_done, byte_rs, proto_err;
  logic [7:0]        byte_val;
  op_e               op;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  assign capture = en_q && !en;
  assign take    = capture && !busy;

  // Byte assembly; in 8-bit mode only the function-set wakeup bytes are legal.
  always_comb begin
    byte_done = 1'b0;
    byte_val  = 8'h00;
    byte_rs   = 1'b0;
    proto_err = 1'b0;
    if (take) begin
      if (!four_bit) begin
        byte_val = {data, 4'h0};
        byte_rs  = rs;
        if (rs || (data != 4'h2 && data != 4'h3)) proto_err = 1'b1;
        else byte_done = 1'b1;
      end else if (phase == PH_LOW) begin
        byte_val = {hi_nib, data};
        byte_rs  = hi_rs;
        if (rs != hi_rs) proto_err = 1'b1;
        else byte_done = 1'b1;
      end
    end
  end

  assign op = decode_op(byte_val);

  // Clear owns the write port while busy; captures are dropped then, so no conflict.
  assign wr_en   = !reset && (busy || (byte_done && byte_rs));
  assign wr_addr = busy ? clr_idx : cursor;
  assign wr_data = busy ? SPACE : byte_val;

  lcd_ddram u_ddram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      phase      <= PH_HIGH;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      inc_mode   <= 1'b1;
      clr_idx    <= '0;
      four_bit   <= 1'b0;
      display_on <= 1'b0;
      cursor     <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'h00;
      cmd_rs     <= 1'b0;
    end else begin
      en_q      <= en;
      cmd_valid <= 1'b0;

      if (busy) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == ADDR_W'(DDRAM_DEPTH - 1)) busy <= 1'b0;
      end

      if ((capture && busy) || proto_err) err <= 1'b1;

      if (take && four_bit) begin
        phase <= (phase == PH_HIGH) ? PH_LOW : PH_HIGH;
        if (phase == PH_HIGH) begin
          hi_nib <= data;
          hi_rs  <= rs;
        end
      end

      if (byte_done) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_val;
        cmd_rs    <= byte_rs;
        if (!four_bit) begin
          if (data == 4'h2) four_bit <= 1'b1;
          phase <= PH_HIGH;
        end else if (byte_rs) begin
          cursor <= inc_mode ? cursor + 1'b1 : cursor - 1'b1;
        end else begin
          case (op)
            OP_SET_DDRAM: begin
              cursor <= {byte_val[ROW1_BIT], byte_val[3:0]};
              if ((byte_val & SET_DDRAM_BAD) != 8'h00) err <= 1'b1;
            end
            OP_FUNC_SET: if (byte_val[FUNC_DL_BIT]) four_bit <= 1'b0;
            OP_DISPLAY:  display_on <= byte_val[DISPLAY_D_BIT];
            OP_ENTRY:    inc_mode <= byte_val[ENTRY_ID_BIT];
            OP_HOME:     cursor <= '0;
            OP_CLEAR: begin
              busy     <= 1'b1;
              clr_idx  <= '0;
              cursor   <= '0;
              inc_mode <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed scenarios plus randomized host traffic checked against a byte-level model.
module tb_lcd_receiver;

  logic       clk = 1'b0;
  logic       reset, en, rs;
  logic [3:0] data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data, cmd_byte;
  logic       cmd_valid, cmd_rs, four_bit, display_on, busy, err;
  logic [4:0] cursor;

  lcd_receiver dut (
    .clk(clk), .reset(reset), .en(en), .rs(rs), .data(data), .rd_addr(rd_addr),
    .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_rs(cmd_rs),
    .four_bit(four_bit), .display_on(display_on), .cursor(cursor), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit       m_four, m_low, m_disp, m_inc, m_err, m_hi_rs;
  bit [3:0] m_hi;
  int       m_cursor, m_busy_left;
  bit [7:0] m_mem [32];
  bit       m_valid [32];
  bit       m_cmd_valid, m_cmd_rs;
  bit [7:0] m_cmd_byte;
  bit       pending, p_rs, model_ok;
  bit [3:0] p_d;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 32 - m_busy_left; k < 32; k++) m_valid[k] = 1'b0;
    m_four = 0; m_low = 0; m_disp = 0; m_inc = 1; m_err = 0;
    m_cursor = 0; m_busy_left = 0; pending = 0; model_ok = 1;
  endfunction

  function automatic void exec_byte(bit [7:0] b, bit r);
    m_cmd_valid = 1; m_cmd_byte = b; m_cmd_rs = r;
    if (r) begin
      m_mem[m_cursor] = b;
      m_valid[m_cursor] = 1;
      m_cursor = (m_cursor + (m_inc ? 1 : 31)) % 32;
    end else if (b >= 128) begin
      m_cursor = (b[6] ? 16 : 0) + (b % 16);
      if (b[5] || b[4]) m_err = 1;
    end else if (b >= 64) begin
    end else if (b >= 32) begin
      if (b[4]) m_four = 0;
    end else if (b >= 16) begin
    end else if (b >= 8) begin
      m_disp = b[2];
    end else if (b >= 4) begin
      m_inc = b[1];
    end else if (b >= 2) begin
      m_cursor = 0;
    end else if (b == 1) begin
      for (int k = 0; k < 32; k++) begin m_mem[k] = 8'h20; m_valid[k] = 1; end
      m_cursor = 0; m_inc = 1; m_busy_left = 32;
    end
  endfunction

  function automatic void apply_nibble(bit r, bit [3:0] d);
    if (!m_four) begin
      if (r || (d != 2 && d != 3)) m_err = 1;
      else begin
        m_cmd_valid = 1; m_cmd_byte = {d, 4'h0}; m_cmd_rs = 0;
        if (d == 2) begin m_four = 1; m_low = 0; end
      end
    end else if (!m_low) begin
      m_hi = d; m_hi_rs = r; m_low = 1;
    end else begin
      m_low = 0;
      if (r != m_hi_rs) m_err = 1;
      else exec_byte({m_hi, d}, r);
    end
  endfunction

  function automatic void model_edge();
    bit was_busy;
    m_cmd_valid = 0;
    if (reset) model_reset();
    else begin
      was_busy = m_busy_left > 0;
      if (was_busy) m_busy_left--;
      if (pending) begin
        pending = 0;
        if (was_busy) m_err = 1;
        else apply_nibble(p_rs, p_d);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rd_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_nibble(input bit r, input bit [3:0] d, input int hold);
    rs = r; data = d; en = 1'b1;
    idle(hold);
    en = 1'b0; pending = 1; p_rs = r; p_d = d;
    tick();
  endtask

  task automatic send_byte(input bit r, input bit [7:0] b);
    send_nibble(r, b[7:4], 1);
    send_nibble(r, b[3:0], 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; pending = 0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy_left > 0 && n < 100) begin tick(); n++; end
  endtask

  task automatic init_seq();
    send_nibble(0, 4'h3, 1); send_nibble(0, 4'h3, 1); send_nibble(0, 4'h3, 1);
    send_nibble(0, 4'h2, 1);
    send_byte(0, 8'h28); send_byte(0, 8'h0C); send_byte(0, 8'h06); send_byte(0, 8'h01);
  endtask

  task automatic peek(input bit [4:0] a, input bit [7:0] exp, input string name);
    rd_addr = a; #1;
    chk(name, rd_data, exp);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset && model_ok) begin
      chk("cmd_valid", cmd_valid, m_cmd_valid);
      if (m_cmd_valid) begin
        chk("cmd_byte", cmd_byte, m_cmd_byte);
        chk("cmd_rs", cmd_rs, m_cmd_rs);
      end
      chk("four_bit", four_bit, m_four);
      chk("display_on", display_on, m_disp);
      chk("cursor", cursor, m_cursor);
      chk("busy", busy, m_busy_left > 0);
      chk("err", err, m_err);
      if (m_busy_left == 0 && m_valid[rd_addr]) chk("rd_data", rd_data, m_mem[rd_addr]);
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  bit [7:0] masks [6] = '{8'h80, 8'h20, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    int n;
    bit [7:0] b, m;
    bit r0;
    reset = 1'b1; en = 1'b0; rs = 1'b0; data = 4'h0; rd_addr = 5'd0;
    for (int k = 0; k < 32; k++) m_valid[k] = 0;
    do_reset();
    chk("rst_four_bit", four_bit, 0); chk("rst_display_on", display_on, 0);
    chk("rst_cursor", cursor, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_cmd_valid", cmd_valid, 0); chk("rst_cmd_byte", cmd_byte, 0); chk("rst_cmd_rs", cmd_rs, 0);

    // Power-up init sequence and clear duration
    init_seq();
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    chk("clear_busy_cycles", n, 32);
    chk("init_four_bit", four_bit, 1); chk("init_display_on", display_on, 1);
    chk("init_cursor", cursor, 0); chk("init_err", err, 0);
    for (int k = 0; k < 32; k++) peek(5'(k), 8'h20, "init_space");

    // Second-row addressing and data writes
    send_byte(0, 8'hC4); send_byte(1, 8'h31); send_byte(1, 8'h32);
    peek(5'd20, 8'h31, "row1_d20"); peek(5'd21, 8'h32, "row1_d21");
    chk("row1_cursor", cursor, 22); chk("row1_err", err, 0);

    // Cursor wrap in both directions
    send_byte(0, 8'hCF); chk("setddr_cursor31", cursor, 31);
    send_byte(1, 8'h41); peek(5'd31, 8'h41, "wrap_d31"); chk("wrap_up_cursor", cursor, 0);
    send_byte(0, 8'h04); send_byte(1, 8'h42);
    peek(5'd0, 8'h42, "wrap_d0"); chk("wrap_down_cursor", cursor, 31);
    chk("wrap_err", err, 0);

    // Nibble landing on the final clear cycle is dropped
    send_byte(0, 8'h01);
    while (m_busy_left > 2) tick();
    chk("pre_drop_busy", busy, 1);
    send_nibble(0, 4'h0, 1);
    chk("drop_err", err, 1);
    send_byte(0, 8'h08);
    chk("after_drop_valid", cmd_valid, 1); chk("after_drop_byte", cmd_byte, 8'h08);
    chk("after_drop_display", display_on, 0);

    // rs mismatch between nibbles
    do_reset();
    send_nibble(0, 4'h2, 1);
    chk("re4_four_bit", four_bit, 1); chk("re4_err", err, 0);
    send_nibble(0, 4'h4, 1); send_nibble(1, 4'h1, 1);
    chk("mismatch_valid", cmd_valid, 0); chk("mismatch_err", err, 1);
    chk("mismatch_cursor", cursor, 0); peek(5'd0, 8'h20, "mismatch_d0");
    send_byte(0, 8'h0C); chk("post_mismatch_display", display_on, 1);

    // Reset abandons a half-received byte
    do_reset();
    send_nibble(0, 4'h2, 1); send_nibble(0, 4'h0, 1);
    do_reset();
    chk("midbyte_four_bit", four_bit, 0);
    send_nibble(0, 4'h3, 1);
    chk("midbyte_valid", cmd_valid, 1); chk("midbyte_byte", cmd_byte, 8'h30);
    chk("midbyte_four_bit2", four_bit, 0);
    tick();
    chk("midbyte_valid_once", cmd_valid, 0);

    // Randomized traffic
    do_reset();
    init_seq();
    wait_idle();
    for (int op = 0; op < 300; op++) begin
      if (!m_four && $urandom_range(0, 1) == 1) send_nibble(0, 4'h2, 1);
      if ($urandom_range(0, 9) != 0) wait_idle();
      n = $urandom_range(0, 99);
      if (n < 4) begin
        do_reset();
        send_nibble(0, 4'h2, 1);
      end else if (n < 10) begin
        send_nibble(1'($urandom), 4'($urandom), $urandom_range(1, 2));
      end else if (n < 15) begin
        b = 8'($urandom); r0 = 1'($urandom);
        send_nibble(r0, b[7:4], 1); send_nibble(!r0, b[3:0], 1);
      end else if (n < 55) begin
        b = 8'($urandom);
        send_nibble(1, b[7:4], $urandom_range(1, 2)); send_nibble(1, b[3:0], $urandom_range(1, 2));
      end else begin
        m = masks[$urandom_range(0, 5)];
        b = m | (8'($urandom) & (m - 8'd1));
        send_byte(0, b);
      end
      idle($urandom_range(0, 2));
    end
    wait_idle();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
